// File: rtl/control_sequencer.sv
// Micro-step sequencer for the 8-bit bus CPU: 3-step fetch, opcode-dependent execute.
// Control outputs are combinational from the current step, opcode and ALU flags.
//
// state | meaning
// ------+-----------------------------------------------------------
// T0    | fetch: PC onto bus, MAR loads
// T1    | fetch: PC increments
// T2    | fetch: RAM onto bus, IR loads
// T3    | execute step 1 (single-step ops end here; HLT parks here)
// T4    | execute step 2 (LDA/STA end here)
// T5    | execute step 3 (ADD/SUB end here)
// halted| flag beside the step counter; step frozen at T3, halt high
module control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int MAX_STEP     = 5
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    carry_flag,
  input  logic                    zero_flag,
  output logic                    pc_inc,
  output logic                    n_pc_enable,
  output logic                    n_pc_load,
  output logic                    n_mar_load,
  output logic                    n_ram_enable,
  output logic                    n_ram_load,
  output logic                    n_ir_load,
  output logic                    n_ir_enable,
  output logic                    n_a_load,
  output logic                    n_a_enable,
  output logic                    n_b_load,
  output logic                    n_alu_enable,
  output logic                    alu_sub,
  output logic                    n_out_load,
  output logic                    halt,
  output logic [2:0]              step
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5
  } step_e;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 4'b0001;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'b0010;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'b0011;
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = 4'b0100;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'b0110;
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = 4'b0111;
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = 4'b1000;
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = 4'b1110;
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'b1111;

  localparam logic [2:0] LAST_STEP = 3'(MAX_STEP);

  step_e step_q, step_d;
  logic  halted_q, halted_d;
  logic  end_step, advance;

  // Active-high internal view of every control line.
  logic a_pc_inc, a_pc_en, a_pc_ld, a_mar_ld, a_ram_en, a_ram_ld;
  logic a_ir_ld, a_ir_en, a_a_ld, a_a_en, a_b_ld, a_alu_en;
  logic a_sub, a_out_ld, a_halt;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    a_pc_inc = 1'b0;
    a_pc_en  = 1'b0;
    a_pc_ld  = 1'b0;
    a_mar_ld = 1'b0;
    a_ram_en = 1'b0;
    a_ram_ld = 1'b0;
    a_ir_ld  = 1'b0;
    a_ir_en  = 1'b0;
    a_a_ld   = 1'b0;
    a_a_en   = 1'b0;
    a_b_ld   = 1'b0;
    a_alu_en = 1'b0;
    a_sub    = 1'b0;
    a_out_ld = 1'b0;
    a_halt   = 1'b0;
    end_step = 1'b0;
    advance  = 1'b1;
    halted_d = halted_q;
    step_d   = step_q;

    if (halted_q) begin
      a_halt  = 1'b1;
      advance = 1'b0;
    end else begin
      unique case (step_q)
        T0: begin
          a_pc_en  = 1'b1;
          a_mar_ld = 1'b1;
        end
        T1: a_pc_inc = 1'b1;
        T2: begin
          a_ram_en = 1'b1;
          a_ir_ld  = 1'b1;
        end
        T3: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              a_ir_en  = 1'b1;
              a_mar_ld = 1'b1;
            end
            OP_JMP: begin
              a_ir_en  = 1'b1;
              a_pc_ld  = 1'b1;
              end_step = 1'b1;
            end
            OP_JC: begin
              a_ir_en  = carry_flag;
              a_pc_ld  = carry_flag;
              end_step = 1'b1;
            end
            OP_JZ: begin
              a_ir_en  = zero_flag;
              a_pc_ld  = zero_flag;
              end_step = 1'b1;
            end
            OP_OUT: begin
              a_a_en   = 1'b1;
              a_out_ld = 1'b1;
              end_step = 1'b1;
            end
            OP_HLT: begin
              a_halt   = 1'b1;
              halted_d = 1'b1;
              advance  = 1'b0;
            end
            default: end_step = 1'b1;
          endcase
        end
        T4: begin
          case (opcode)
            OP_LDA: begin
              a_ram_en = 1'b1;
              a_a_ld   = 1'b1;
              end_step = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              a_ram_en = 1'b1;
              a_b_ld   = 1'b1;
            end
            OP_STA: begin
              a_a_en   = 1'b1;
              a_ram_ld = 1'b1;
              end_step = 1'b1;
            end
            default: end_step = 1'b1;
          endcase
        end
        T5: begin
          a_alu_en = 1'b1;
          a_a_ld   = 1'b1;
          a_sub    = (opcode == OP_SUB);
          end_step = 1'b1;
        end
        default: end_step = 1'b1;
      endcase
    end

    // Wrap only through an end step; the last-step guard keeps an IR glitch
    // between T3 and T4 from ever walking the counter past T5.
    if (end_step || (step_q >= LAST_STEP && !halted_q)) begin
      step_d = T0;
    end else if (advance) begin
      step_d = step_e'(step_q + 3'd1);
    end
  end

  // Clear forces every line inactive in the same cycle, not just after the edge.
  always_comb begin
    pc_inc       =  a_pc_inc & ~clear;
    n_pc_enable  = ~(a_pc_en  & ~clear);
    n_pc_load    = ~(a_pc_ld  & ~clear);
    n_mar_load   = ~(a_mar_ld & ~clear);
    n_ram_enable = ~(a_ram_en & ~clear);
    n_ram_load   = ~(a_ram_ld & ~clear);
    n_ir_load    = ~(a_ir_ld  & ~clear);
    n_ir_enable  = ~(a_ir_en  & ~clear);
    n_a_load     = ~(a_a_ld   & ~clear);
    n_a_enable   = ~(a_a_en   & ~clear);
    n_b_load     = ~(a_b_ld   & ~clear);
    n_alu_enable = ~(a_alu_en & ~clear);
    alu_sub      =  a_sub & ~clear;
    n_out_load   = ~(a_out_ld & ~clear);
    halt         =  a_halt & ~clear;
  end

  assign step = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: the driver pushes the expected control
// word for every cycle it drives; a negedge monitor pops and compares.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       carry_flag = 1'b0;
  logic       zero_flag = 1'b0;
  logic       pc_inc, n_pc_enable, n_pc_load, n_mar_load, n_ram_enable, n_ram_load;
  logic       n_ir_load, n_ir_enable, n_a_load, n_a_enable, n_b_load, n_alu_enable;
  logic       alu_sub, n_out_load, halt;
  logic [2:0] step;

  control_sequencer #(.OPCODE_WIDTH(4), .MAX_STEP(5)) dut (
    .clk(clk), .clear(clear), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .pc_inc(pc_inc), .n_pc_enable(n_pc_enable), .n_pc_load(n_pc_load),
    .n_mar_load(n_mar_load), .n_ram_enable(n_ram_enable), .n_ram_load(n_ram_load),
    .n_ir_load(n_ir_load), .n_ir_enable(n_ir_enable), .n_a_load(n_a_load),
    .n_a_enable(n_a_enable), .n_b_load(n_b_load), .n_alu_enable(n_alu_enable),
    .alu_sub(alu_sub), .n_out_load(n_out_load), .halt(halt), .step(step)
  );

  always #5 clk = ~clk;

  localparam int B_PC_INC = 0, B_PC_EN = 1, B_PC_LD = 2, B_MAR_LD = 3, B_RAM_EN = 4;
  localparam int B_RAM_LD = 5, B_IR_LD = 6, B_IR_EN = 7, B_A_LD = 8, B_A_EN = 9;
  localparam int B_B_LD = 10, B_ALU_EN = 11, B_SUB = 12, B_OUT_LD = 13, B_HALT = 14;

  localparam logic [3:0] NOP = 4'h0, LDA = 4'h1, ADD = 4'h2, SUB = 4'h3, STA = 4'h4;
  localparam logic [3:0] JMP = 4'h6, JC = 4'h7, JZ = 4'h8, OUTI = 4'he, HLT = 4'hf;

  typedef struct {
    logic [14:0] act;
    logic [2:0]  stp;
    logic [3:0]  op;
    int          k;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   cyc = 0;

  logic [14:0] obs_act;
  assign obs_act = {halt, ~n_out_load, alu_sub, ~n_alu_enable, ~n_b_load, ~n_a_enable,
                    ~n_a_load, ~n_ir_enable, ~n_ir_load, ~n_ram_load, ~n_ram_enable,
                    ~n_mar_load, ~n_pc_load, ~n_pc_enable, pc_inc};

  // Instruction length in cycles, fetch included.
  function automatic int ilen(input logic [3:0] op);
    case (op)
      LDA, STA: return 5;
      ADD, SUB: return 6;
      default:  return 4;
    endcase
  endfunction

  // Active-high set of control lines for step k of instruction op.
  function automatic logic [14:0] exp_act(input logic [3:0] op, input int k,
                                          input logic c, input logic z);
    logic [14:0] r;
    r = '0;
    if (k == 0) begin r[B_PC_EN] = 1'b1; r[B_MAR_LD] = 1'b1; end
    else if (k == 1) r[B_PC_INC] = 1'b1;
    else if (k == 2) begin r[B_RAM_EN] = 1'b1; r[B_IR_LD] = 1'b1; end
    else begin
      case (op)
        LDA: if (k == 3) begin r[B_IR_EN] = 1'b1; r[B_MAR_LD] = 1'b1; end
             else begin r[B_RAM_EN] = 1'b1; r[B_A_LD] = 1'b1; end
        ADD, SUB:
          if (k == 3) begin r[B_IR_EN] = 1'b1; r[B_MAR_LD] = 1'b1; end
          else if (k == 4) begin r[B_RAM_EN] = 1'b1; r[B_B_LD] = 1'b1; end
          else begin r[B_ALU_EN] = 1'b1; r[B_A_LD] = 1'b1; r[B_SUB] = (op == SUB); end
        STA: if (k == 3) begin r[B_IR_EN] = 1'b1; r[B_MAR_LD] = 1'b1; end
             else begin r[B_A_EN] = 1'b1; r[B_RAM_LD] = 1'b1; end
        JMP: begin r[B_IR_EN] = 1'b1; r[B_PC_LD] = 1'b1; end
        JC:  begin r[B_IR_EN] = c; r[B_PC_LD] = c; end
        JZ:  begin r[B_IR_EN] = z; r[B_PC_LD] = z; end
        OUTI: begin r[B_A_EN] = 1'b1; r[B_OUT_LD] = 1'b1; end
        HLT: r[B_HALT] = 1'b1;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic push(input logic [14:0] a, input logic [2:0] s, input logic [3:0] op,
                      input int k);
    exp_t e;
    e.act = a; e.stp = s; e.op = op; e.k = k;
    sb.push_back(e);
    mon_en = 1'b1;
  endtask

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    clear = 1'b0;
    cyc++;
  endtask

  task automatic clear_cycle();
    begin_cycle();
    clear = 1'b1;
    carry_flag = 1'($urandom_range(0, 1));
    zero_flag  = 1'($urandom_range(0, 1));
    push('0, 3'd0, opcode, -1);
  endtask

  // cm/zm < 0 means random flag at T3; clear_at >= 0 aborts with clear at that step.
  task automatic run_instr(input logic [3:0] op, input int cm, input int zm,
                           input int clear_at, input int hold);
    int n;
    n = ilen(op);
    for (int k = 0; k < n; k++) begin
      if (k == clear_at) begin
        clear_cycle();
        return;
      end
      begin_cycle();
      if (k == 0) opcode = op;
      carry_flag = 1'($urandom_range(0, 1));
      zero_flag  = 1'($urandom_range(0, 1));
      if (k == 3 && cm >= 0) carry_flag = cm[0];
      if (k == 3 && zm >= 0) zero_flag = zm[0];
      push(exp_act(op, k, carry_flag, zero_flag), 3'(k), op, k);
    end
    if (op == HLT) begin
      for (int h = 0; h < hold; h++) begin
        begin_cycle();
        opcode = (h % 3 == 0) ? LDA : 4'($urandom_range(0, 15));
        carry_flag = 1'($urandom_range(0, 1));
        zero_flag  = 1'($urandom_range(0, 1));
        push(15'(1) << B_HALT, 3'd3, opcode, 3);
      end
      clear_cycle();
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow cycle %0d: DUT act=%h step=%0d, no expectation queued",
                   cyc, obs_act, step);
        end else begin
          mon_e = sb.pop_front();
          if (obs_act !== mon_e.act || step !== mon_e.stp) begin
            errors++;
            $display("FAIL ctrl cycle %0d op=%h k=%0d: got act=%h step=%0d, expected act=%h step=%0d",
                     cyc, mon_e.op, mon_e.k, obs_act, step, mon_e.act, mon_e.stp);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int op_r, ca;
    repeat (3) clear_cycle();
    run_instr(ADD, -1, -1, 4, 0);
    run_instr(LDA, -1, -1, -1, 0);
    run_instr(SUB, -1, -1, -1, 0);
    run_instr(JC, 1, -1, -1, 0);
    run_instr(JC, 0, -1, -1, 0);
    run_instr(JZ, -1, 1, -1, 0);
    run_instr(JZ, -1, 0, -1, 0);
    run_instr(STA, -1, -1, -1, 0);
    run_instr(JMP, -1, -1, -1, 0);
    run_instr(OUTI, -1, -1, -1, 0);
    run_instr(4'ha, -1, -1, -1, 0);
    run_instr(NOP, -1, -1, -1, 0);
    run_instr(HLT, -1, -1, -1, 25);
    run_instr(LDA, -1, -1, -1, 0);
    for (int i = 0; i < 400; i++) begin
      op_r = $urandom_range(0, 15);
      ca = ($urandom_range(0, 19) == 0) ? $urandom_range(0, ilen(4'(op_r)) - 1) : -1;
      run_instr(4'(op_r), -1, -1, ca, $urandom_range(20, 30));
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
